// File: rtl/oled_wave_pkg.sv
// Shared types and constants for the queued SSD1306 waveform plotter.
package oled_wave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_SEL_DONE,
    ST_HEADER,
    ST_PIXEL,
    ST_TX
  } state_e;

  typedef enum logic [1:0] {
    OP_PIX = 2'd0,
    OP_RAW = 2'd1,
    OP_SEL = 2'd2
  } op_e;

  localparam logic [3:0] ADDR_PIX  = 4'h0;
  localparam logic [3:0] ADDR_RAW  = 4'h1;
  localparam logic [3:0] ADDR_CFG0 = 4'h2;
  localparam logic [3:0] ADDR_CFG1 = 4'h3;
  localparam logic [3:0] ADDR_SEL  = 4'h8;

  localparam int STS_IDLE  = 0;
  localparam int STS_EMPTY = 1;
  localparam int STS_FULL  = 2;
  localparam int STS_OVF   = 3;

endpackage

// File: rtl/font_rom.sv
// 7-column digit glyphs 0..7 for the page header; columns 0 and 6 are blank spacers.
module font_rom (
  input  logic [2:0] digit_i,
  input  logic [2:0] column_i,
  output logic [7:0] data_o
);

  logic [39:0] glyph;

  always_comb begin
    case (digit_i)
      3'd0:    glyph = 40'h3E_51_49_45_3E;
      3'd1:    glyph = 40'h00_42_7F_40_00;
      3'd2:    glyph = 40'h42_61_51_49_46;
      3'd3:    glyph = 40'h21_41_45_4B_31;
      3'd4:    glyph = 40'h18_14_12_7F_10;
      3'd5:    glyph = 40'h27_45_45_45_39;
      3'd6:    glyph = 40'h3C_4A_49_49_30;
      default: glyph = 40'h01_71_09_05_03;
    endcase
    data_o = 8'h00;
    if (column_i >= 3'd1 && column_i <= 3'd5)
      data_o = glyph[(3'd5 - column_i) * 8 +: 8];
  end

endmodule

// File: rtl/oled_wave_plotter_q_cmd_fifo.sv
// Synchronous command FIFO; a push while full is still taken when a pop frees a slot that cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/oled_wave_plotter_q.sv
// TinyQV peripheral: queued commands rendered as SSD1306 column bytes over mode-0 SPI.
module oled_wave_plotter_q
  import oled_wave_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         PRESC_W    = 4,
  parameter int         PAGE_W     = 3,
  parameter logic [7:0] HI_PAT     = 8'h02,
  parameter logic [7:0] LO_PAT     = 8'h40,
  parameter logic [7:0] EDGE_PAT   = 8'h7E,
  parameter logic       CPOL       = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  logic               hdr_q, gnd_q, cs_q, dc_q, dc_d, dc_fsm, edge_q, ovf_q;
  logic [PRESC_W-1:0] presc_q, presc_lat_q, presc_lat_d, div_q, div_d;
  logic [1:0]         stretch_q, col_q, col_d;
  state_e             state_q, state_d, ret_q, ret_d;
  logic [7:0]         shift_q, shift_d, pix_q, pix_d, font_byte, col_byte;
  logic [3:0]         tog_q, tog_d;
  logic [2:0]         samp_q, samp_d, hcol_q, hcol_d;
  logic [PAGE_W-1:0]  page_q, page_d;
  logic               sck_q, sck_d, prev_q, prev_d, pix_bit, load;
  logic               push, pop, full, empty, cfg0_wr, cfg1_wr;
  op_e                push_op, head_op;
  logic [9:0]         head;
  logic               unused_in;

  assign unused_in = ^ui_in;
  assign cfg0_wr   = data_write && (address == ADDR_CFG0);
  assign cfg1_wr   = data_write && (address == ADDR_CFG1);
  assign pop       = (state_q == ST_IDLE) && !empty;
  assign head_op   = op_e'(head[9:8]);

  always_comb begin
    push    = 1'b0;
    push_op = OP_RAW;
    if (data_write) begin
      case (address)
        ADDR_PIX: begin push = 1'b1; push_op = OP_PIX; end
        ADDR_RAW: begin push = 1'b1; push_op = OP_RAW; end
        ADDR_SEL: begin push = 1'b1; push_op = OP_SEL; end
        default:  ;
      endcase
    end
  end

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(10)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({push_op, data_in}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  font_rom u_font (
    .digit_i  (3'(page_q)),
    .column_i (hcol_q),
    .data_o   (font_byte)
  );

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    shift_d     = shift_q;
    sck_d       = sck_q;
    div_d       = div_q;
    presc_lat_d = presc_lat_q;
    tog_d       = tog_q;
    pix_d       = pix_q;
    samp_d      = samp_q;
    col_d       = col_q;
    hcol_d      = hcol_q;
    prev_d      = prev_q;
    page_d      = page_q;
    dc_fsm      = dc_q;
    load        = 1'b0;
    pix_bit     = pix_q[3'd7 - samp_q];
    // Edge pattern only marks the first column of a sample that differs from the previous one.
    if (edge_q && (col_q == 2'd0) && (pix_bit != prev_q)) col_byte = EDGE_PAT;
    else if (pix_bit)                                     col_byte = HI_PAT;
    else                                                  col_byte = LO_PAT;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          case (head_op)
            OP_RAW: begin shift_d = head[7:0]; ret_d = ST_IDLE; load = 1'b1; end
            OP_SEL: begin page_d = head[PAGE_W-1:0]; state_d = ST_SEL; end
            OP_PIX: begin pix_d = head[7:0]; samp_d = 3'd0; col_d = 2'd0; state_d = ST_PIXEL; end
            default: ;
          endcase
        end
      end
      ST_SEL: begin
        dc_fsm  = 1'b0;
        shift_d = 8'hB0 | 8'(page_q);
        ret_d   = ST_SEL_DONE;
        load    = 1'b1;
      end
      ST_SEL_DONE: begin
        dc_fsm  = 1'b1;
        prev_d  = 1'b0;
        hcol_d  = 3'd0;
        state_d = hdr_q ? ST_HEADER : ST_IDLE;
      end
      ST_HEADER: begin
        shift_d = font_byte | {gnd_q, 7'b0};
        hcol_d  = hcol_q + 3'd1;
        ret_d   = (hcol_q == 3'd6) ? ST_IDLE : ST_HEADER;
        load    = 1'b1;
      end
      ST_PIXEL: begin
        shift_d = col_byte | {gnd_q, 7'b0};
        if (col_q == 2'd0) prev_d = pix_bit;
        if (col_q == stretch_q) begin
          col_d  = 2'd0;
          samp_d = samp_q + 3'd1;
          ret_d  = (samp_q == 3'd7) ? ST_IDLE : ST_PIXEL;
        end else begin
          col_d  = col_q + 2'd1;
          ret_d  = ST_PIXEL;
        end
        load = 1'b1;
      end
      ST_TX: begin
        if (div_q == presc_lat_q) begin
          div_d = '0;
          sck_d = ~sck_q;
          tog_d = tog_q + 4'd1;
          if (sck_q != CPOL) shift_d = {shift_q[6:0], 1'b0};
          if (tog_q == 4'd15) state_d = ret_q;
        end else begin
          div_d = div_q + PRESC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d     = ST_TX;
      presc_lat_d = presc_q;
      div_d       = '0;
      tog_d       = 4'd0;
      sck_d       = CPOL;
    end
    dc_d = cfg0_wr ? data_in[4] : dc_fsm;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_q     <= 1'b0;
      gnd_q     <= 1'b0;
      cs_q      <= 1'b1;
      dc_q      <= 1'b0;
      presc_q   <= PRESC_W'(4);
      stretch_q <= 2'd0;
      edge_q    <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      sck_q     <= CPOL;
      div_q     <= '0;
      tog_q     <= 4'd0;
      samp_q    <= 3'd0;
      col_q     <= 2'd0;
      hcol_q    <= 3'd0;
      prev_q    <= 1'b0;
    end else begin
      dc_q    <= dc_d;
      state_q <= state_d;
      ret_q   <= ret_d;
      sck_q   <= sck_d;
      div_q   <= div_d;
      tog_q   <= tog_d;
      samp_q  <= samp_d;
      col_q   <= col_d;
      hcol_q  <= hcol_d;
      prev_q  <= prev_d;
      if (cfg0_wr) begin
        hdr_q   <= data_in[7];
        gnd_q   <= data_in[6];
        cs_q    <= data_in[5];
        presc_q <= data_in[PRESC_W-1:0];
      end
      if (cfg1_wr) begin
        stretch_q <= data_in[1:0];
        edge_q    <= data_in[2];
      end
      if (cfg1_wr && data_in[7])         ovf_q <= 1'b0;
      else if (push && full && !pop)     ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    shift_q     <= shift_d;
    pix_q       <= pix_d;
    page_q      <= page_d;
    presc_lat_q <= presc_lat_d;
  end

  always_comb begin
    uo_out      = 8'h00;
    uo_out[1]   = sck_q;
    uo_out[2]   = (state_q == ST_TX) && shift_q[7];
    uo_out[3]   = cs_q && (state_q != ST_TX);
    uo_out[4]   = dc_q;
    data_out    = 8'h00;
    data_out[STS_IDLE]  = (state_q == ST_IDLE) && empty;
    data_out[STS_EMPTY] = empty;
    data_out[STS_FULL]  = full;
    data_out[STS_OVF]   = ovf_q;
  end

endmodule

// File: tb/tb_oled_wave_plotter_q.sv
// Scoreboard bench: commands are expanded by a behavioural model into expected {DC, byte} SPI transfers.
module tb_oled_wave_plotter_q;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in, uo_out, data_in, data_out;
  logic [3:0] address;
  logic       data_write;

  always #5 clk = ~clk;

  oled_wave_plotter_q dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [8:0] expq[$];
  logic       mon_clear = 1'b0;

  logic       m_dc, m_prev, m_gnd, m_hdr, m_edge;
  int         m_stretch, m_presc;
  logic [7:0] font_tab [8][7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SPI monitor: assemble MOSI on rising SCK, compare each completed byte with the scoreboard head.
  initial begin : monitor
    logic       sck_prev;
    int         nb;
    logic [7:0] sh;
    logic       dcb;
    logic [8:0] e;
    sck_prev = 1'b0;
    nb = 0;
    sh = 8'h00;
    dcb = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_clear) begin
        nb = 0;
        mon_clear = 1'b0;
      end else if (uo_out[1] && !sck_prev) begin
        sh = {sh[6:0], uo_out[2]};
        if (nb == 0) begin
          dcb = uo_out[4];
          check("cs_n_low_in_byte", {31'b0, uo_out[3]}, 32'd0);
        end
        nb++;
        if (nb == 8) begin
          nb = 0;
          check("dc_stable_in_byte", {31'b0, uo_out[4]}, {31'b0, dcb});
          if (expq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spi_byte: got %0h with no transfer expected", {dcb, sh});
          end else begin
            e = expq.pop_front();
            check("spi_byte", {23'b0, dcb, sh}, {23'b0, e});
          end
        end
      end
      sck_prev = uo_out[1];
    end
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a;
    data_in = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic cfg0(input logic [7:0] v);
    wr(4'h2, v);
    m_hdr = v[7];
    m_gnd = v[6];
    m_dc = v[4];
    m_presc = int'(v[3:0]);
  endtask

  task automatic cfg1(input logic [7:0] v);
    wr(4'h3, v);
    m_stretch = int'(v[1:0]) + 1;
    m_edge = v[2];
  endtask

  task automatic model(input int op, input logic [7:0] b);
    logic [7:0] col;
    logic       bitv;
    if (op == 1) begin
      expq.push_back({m_dc, b});
    end else if (op == 2) begin
      expq.push_back({1'b0, 8'hB0 | {5'b0, b[2:0]}});
      m_dc = 1'b1;
      m_prev = 1'b0;
      if (m_hdr)
        for (int c = 0; c < 7; c++) expq.push_back({1'b1, font_tab[b[2:0]][c] | {m_gnd, 7'b0}});
    end else begin
      for (int i = 7; i >= 0; i--) begin
        bitv = b[i];
        for (int c = 0; c < m_stretch; c++) begin
          if (m_edge && c == 0 && bitv != m_prev) col = 8'h7E;
          else col = bitv ? 8'h02 : 8'h40;
          if (m_gnd) col[7] = 1'b1;
          expq.push_back({m_dc, col});
        end
        m_prev = bitv;
      end
    end
  endtask

  task automatic cmd(input int op, input logic [7:0] b);
    logic [3:0] a;
    a = (op == 0) ? 4'h0 : (op == 1) ? 4'h1 : 4'h8;
    wr(a, b);
    model(op, b);
  endtask

  task automatic wait_idle(input int budget);
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (data_out[0]) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
  endtask

  task automatic model_reset();
    m_dc = 1'b0; m_prev = 1'b0; m_gnd = 1'b0; m_hdr = 1'b0; m_edge = 1'b0;
    m_stretch = 1; m_presc = 4;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int first_sck, cs_low, nops, t;
    logic [7:0] v;
    font_tab = '{
      '{8'h00, 8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E, 8'h00},
      '{8'h00, 8'h00, 8'h42, 8'h7F, 8'h40, 8'h00, 8'h00},
      '{8'h00, 8'h42, 8'h61, 8'h51, 8'h49, 8'h46, 8'h00},
      '{8'h00, 8'h21, 8'h41, 8'h45, 8'h4B, 8'h31, 8'h00},
      '{8'h00, 8'h18, 8'h14, 8'h12, 8'h7F, 8'h10, 8'h00},
      '{8'h00, 8'h27, 8'h45, 8'h45, 8'h45, 8'h39, 8'h00},
      '{8'h00, 8'h3C, 8'h4A, 8'h49, 8'h49, 8'h30, 8'h00},
      '{8'h00, 8'h01, 8'h71, 8'h09, 8'h05, 8'h03, 8'h00}
    };
    ui_in = 8'h00; address = 4'h0; data_in = 8'h00; data_write = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_status", {24'b0, data_out}, 32'h03);
    check("reset_pins", {24'b0, uo_out}, 32'h08);

    // RAW A5 at presc 0: latency, CS_N window and bit order.
    cfg0(8'h20);
    cmd(1, 8'hA5);
    first_sck = -1;
    cs_low = 0;
    for (t = 1; t < 200; t++) begin
      @(negedge clk);
      if (uo_out[1] && first_sck < 0) first_sck = t;
      if (!uo_out[3]) cs_low++;
      if (data_out[0]) break;
    end
    check("first_sck_latency", first_sck + 1, m_presc + 3);
    check("cs_low_cycles", cs_low, 16 * (m_presc + 1));
    check("idle_after_raw", {24'b0, data_out}, 32'h03);

    // Page select then a plain pixel byte.
    cmd(2, 8'h03);
    cmd(0, 8'hF0);
    wait_idle(2000);
    check("dc_after_sel", {31'b0, uo_out[4]}, 32'd1);

    // Edge mode, stretch 2, then ground bit.
    cfg1(8'h05);
    cmd(0, 8'h80);
    wait_idle(2000);
    cfg0(8'h70);
    cmd(0, 8'($urandom));
    wait_idle(2000);

    // Overflow at presc 15, then a push coinciding with the pop.
    cfg0(8'h3F);
    cfg1(8'h00);
    cmd(1, 8'h11);
    repeat (3) @(negedge clk);
    cmd(1, 8'h22); cmd(1, 8'h33); cmd(1, 8'h44); cmd(1, 8'h55);
    check("fifo_full_status", {24'b0, data_out}, 32'h04);
    wr(4'h1, 8'h66);
    check("ovf_status", {24'b0, data_out}, 32'h0C);
    cfg1(8'h80);
    check("ovf_cleared", {24'b0, data_out}, 32'h04);
    for (t = 0; t < 600; t++) begin
      if (uo_out[3]) break;
      @(negedge clk);
    end
    if (!uo_out[3]) begin
      n_cmp++; n_fail++;
      $display("FAIL cs_release_timeout: CS_N still 0, required 1");
    end
    cmd(1, 8'h77);
    check("push_with_pop_accepted", {24'b0, data_out}, 32'h04);
    wait_idle(5000);

    // Header digits after page select.
    cfg0(8'hB1);
    cmd(2, 8'h05);
    wait_idle(2000);
    check("idle_after_header", {24'b0, data_out}, 32'h03);

    // Randomised rounds.
    for (int r = 0; r < 6; r++) begin
      v = {1'($urandom), 1'($urandom), 1'b1, 1'($urandom), 3'b000, 1'($urandom)};
      cfg0(v);
      cfg1({5'b0, 3'($urandom)});
      nops = $urandom_range(1, 3);
      for (int k = 0; k < nops; k++) cmd($urandom_range(0, 2), 8'($urandom));
      wait_idle(12000);
      check("round_idle_status", {24'b0, data_out}, 32'h03);
    end

    // Reset in the middle of a byte flushes the queue.
    cfg0(8'h21);
    cmd(1, 8'hC3); cmd(1, 8'h3C); cmd(1, 8'h5A);
    for (t = 0; t < 50; t++) begin
      if (!uo_out[3]) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    mon_clear = 1'b1;
    rst_n = 1'b0;
    expq.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_sck", {31'b0, uo_out[1]}, 32'd0);
    check("rst_mid_cs_n", {31'b0, uo_out[3]}, 32'd1);
    check("rst_mid_status", {24'b0, data_out}, 32'h03);
    repeat (300) @(negedge clk);
    check("rst_flush_status", {24'b0, data_out}, 32'h03);
    check("rst_flush_pins", {24'b0, uo_out}, 32'h08);

    check("leftover_expected", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
